// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, handshakes with imem,
// fills the single-entry IF/ID slot. Option: IF_MISALIGN_TRAP_EN.
module if_fetch_unit #(
    parameter int              PC_W     = 32,
    parameter int              PRED_W   = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [PC_W-1:0]   fetch_pc,
    input  logic              pred_taken,
    input  logic [PRED_W-1:0] pred_target,
    input  logic              refetch,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic              FD_stall,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              inst_valid,
    output logic [31:0]       inst_IF,
    output logic [PC_W-1:0]   PC_IF_out,
    output logic              taken_out,
    output logic [PC_W-1:0]   PC_pre_out
`ifdef IF_MISALIGN_TRAP_EN
    ,
    output logic              misalign_out
`endif
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP,
        HALT
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [PC_W-1:0] drop_addr;
    logic [PC_W-1:0] pred_pc;
    logic [PC_W-1:0] seq_pc;
    logic            can_accept;
    logic            misalign;
    logic            fill;
    logic            trap;

    assign can_accept = !inst_valid || !FD_stall;
    assign pred_pc    = {fetch_pc[PC_W-1:PRED_W], pred_target};
    assign seq_pc     = fetch_pc + PC_W'(4);

`ifdef IF_MISALIGN_TRAP_EN
    assign misalign = (fetch_pc[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // State register; reset abandons any outstanding request.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next state, memory request and slot fill/trap strobes.
    always_comb begin
        state_nx  = state;
        imem_req  = 1'b0;
        imem_addr = fetch_pc;
        fill      = 1'b0;
        trap      = 1'b0;
        unique case (state)
            IDLE: begin
                state_nx = REQ;
            end
            REQ: begin
                imem_req = can_accept && !misalign;
                if (refetch) begin
                    if (imem_req && !imem_ack)
                        state_nx = DROP;
                end else if (imem_req && imem_ack) begin
                    fill = 1'b1;
                end else if (can_accept && misalign) begin
                    trap     = 1'b1;
                    state_nx = HALT;
                end
            end
            DROP: begin
                imem_req  = 1'b1;
                imem_addr = drop_addr;
                if (imem_ack)
                    state_nx = REQ;
            end
            HALT: begin
                if (refetch)
                    state_nx = REQ;
            end
        endcase
    end

    // Fetch PC, in-flight address for DROP, and the IF/ID slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc   <= RESET_PC;
            drop_addr  <= '0;
            inst_valid <= 1'b0;
            inst_IF    <= NOP;
            PC_IF_out  <= '0;
            taken_out  <= 1'b0;
            PC_pre_out <= '0;
`ifdef IF_MISALIGN_TRAP_EN
            misalign_out <= 1'b0;
`endif
        end else begin
            if (state != DROP)
                drop_addr <= fetch_pc;
            if (refetch) begin
                fetch_pc   <= redirect_pc;
                inst_valid <= 1'b0;
            end else if (fill) begin
                fetch_pc   <= pred_taken ? pred_pc : seq_pc;
                inst_valid <= 1'b1;
                inst_IF    <= imem_rdata;
                PC_IF_out  <= fetch_pc;
                taken_out  <= pred_taken;
                PC_pre_out <= pred_pc;
`ifdef IF_MISALIGN_TRAP_EN
                misalign_out <= 1'b0;
`endif
            end else if (trap) begin
                inst_valid <= 1'b1;
                inst_IF    <= NOP;
                PC_IF_out  <= fetch_pc;
                taken_out  <= 1'b0;
                PC_pre_out <= '0;
`ifdef IF_MISALIGN_TRAP_EN
                misalign_out <= 1'b1;
`endif
            end else if (!FD_stall) begin
                inst_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch front end directly upstream of the branch predict unit.
- Owns the fetch PC register and drives it to the predictor as the IF-stage PC.
- Consumes the predictor's IF-stage prediction (taken flag, 8-bit target) to choose the next PC, and its ID-stage refetch to redirect.
- Runs a req/ack handshake to instruction memory and fills a single-entry IF/ID output slot that the decode stage drains.

Parameters:
- PC_W, 32: fetch PC width in bits.
- PRED_W, 8: width of the predictor target field. The predicted PC is {fetch_pc[PC_W-1:PRED_W], pred_target}.
- RESET_PC, 0: fetch PC loaded at reset.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_pc  out  PC_W  current fetch PC, fed to the predictor's IF-stage PC input.
- pred_taken  in  1  predictor IF-stage taken flag for fetch_pc.
- pred_target  in  PRED_W  predictor IF-stage target for fetch_pc.
- refetch  in  1  predictor misprediction flag, from its ID-stage comparison.
- redirect_pc  in  PC_W  correct next PC while refetch=1.
- FD_stall  in  1  decode stage cannot accept the output slot this cycle.
- imem_req  out  1  instruction memory request.
- imem_addr  out  PC_W  request address.
- imem_ack  in  1  response valid; may arrive in the request cycle or any later cycle.
- imem_rdata  in  32  instruction word.
- inst_valid  out  1  output slot holds a valid instruction.
- inst_IF  out  32  slot instruction.
- PC_IF_out  out  PC_W  slot instruction PC.
- taken_out  out  1  prediction recorded with the slot instruction.
- PC_pre_out  out  PC_W  predicted target recorded with the slot instruction.

Behaviour:
- Interface (already decided): single clock clk; rst is synchronous and active-high, with no asynchronous path.
- Reset values:
  - fetch_pc = RESET_PC; state = IDLE.
  - imem_req = 0, inst_valid = 0, inst_IF = 32'h00000013 (NOP), PC_IF_out = 0, taken_out = 0, PC_pre_out = 0.
- Asserting rst mid-request abandons the request. Memory must tolerate a dropped request.
- FSM state IDLE:
  - imem_req = 0.
  - Go to REQ on the first cycle without rst.
- FSM state REQ:
  - imem_req = 1 and imem_addr = fetch_pc, held stable until imem_ack.
  - Request only while the slot can accept: slot empty, or FD_stall = 0. Otherwise imem_req = 0 and fetch_pc is held.
  - On imem_ack with no refetch:
    - slot <= {imem_rdata, fetch_pc, pred_taken, predicted PC}; inst_valid <= 1.
    - fetch_pc <= pred_taken ? {fetch_pc[PC_W-1:PRED_W], pred_target} : fetch_pc + 4.
    - Addition wraps modulo 2^PC_W.
- FSM state DROP:
  - Entered when refetch occurs while a request is outstanding and imem_ack = 0.
  - imem_req stays 1 with the old address until imem_ack.
  - The response is discarded; then go to REQ at the already-loaded redirect PC.
- Slot drain:
  - If FD_stall = 0 and no new fill, inst_valid <= 0.
  - If FD_stall = 1, all slot fields are held.
- Refetch (highest priority, applies regardless of FD_stall):
  - fetch_pc <= redirect_pc; inst_valid <= 0 (wrong-path flush of the slot).
  - If imem_ack is in the same cycle, rdata is discarded and the state goes to REQ.
  - The ID-stage instruction itself is not flushed by this block.
- Latency: request to slot is 1 cycle after imem_ack. Zero-wait memory sustains one instruction per cycle with no bubbles on predicted-taken branches.
- Refetch penalty: 1 cycle of inst_valid = 0 with zero-wait memory.
- Simultaneous refetch and rst: rst wins.

Optional Feature:
- Macro name: IF_MISALIGN_TRAP_EN.
- When defined:
  - Adds output misalign_out (1 bit), which travels with the slot.
  - A redirect or predicted target with bits [1:0] != 0 does not request memory.
  - Instead the slot is filled with NOP, inst_valid = 1, misalign_out = 1, and fetch stalls.
  - Fetch remains stalled until the next refetch.
  - misalign_out resets to 0.
- When undefined:
  - The port is absent.
  - Targets are used unchanged; the low bits are passed on imem_addr.

Test Plan:
1. Reset, zero-wait ack every cycle, pred_taken = 0 → imem_addr sequence 0, 4, 8, 12; inst_valid = 1 from the second cycle after reset release; PC_IF_out lags imem_addr by 1 cycle.
2. At fetch_pc = 0x10: pred_taken = 1, pred_target = 0x40 → next imem_addr 0x40; slot for 0x10 has taken_out = 1, PC_pre_out = 0x40.
3. Hold FD_stall = 1 for 3 cycles with the slot full → imem_req = 0; slot fields unchanged; fetch resumes at the held fetch_pc the cycle after FD_stall falls.
4. Ack delayed 3 cycles, refetch = 1 with redirect_pc = 0x80 in the first wait cycle → DROP state; the old response is discarded; the next request is 0x80; no wrong-path instruction appears in the slot.
5. refetch with redirect_pc = 0x24 in the same cycle as imem_ack → rdata discarded; inst_valid = 0 for 1 cycle; the next slot PC is 0x24.
6. fetch_pc = 0xFFFFFFFC, pred_taken = 0 → next fetch_pc = 0x00000000. With IF_MISALIGN_TRAP_EN: redirect_pc = 0x22 → misalign_out = 1, inst_IF = NOP, no imem_req.
